// File: rtl/frog_mover_if.sv
// Move/collision inputs and frog status outputs between the button/traffic
// logic (master) and the frog_mover (slave).
interface frog_mover_if #(
    parameter int ROWS    = 16,
    parameter int COLS    = 16,
    parameter int LIVES   = 3,
    parameter int SCORE_W = 4
);
    logic                       up;
    logic                       down;
    logic                       left;
    logic                       right;
    logic                       hit;
    logic [$clog2(ROWS)-1:0]    frog_row;
    logic [$clog2(COLS)-1:0]    frog_col;
    logic [$clog2(LIVES+1)-1:0] lives;
    logic [SCORE_W-1:0]         score;
    logic                       playing;
    logic                       game_over;
    logic                       win_pulse;
    logic                       die_pulse;

    modport master (
        output up, down, left, right, hit,
        input  frog_row, frog_col, lives, score, playing, game_over, win_pulse, die_pulse
    );

    modport slave (
        input  up, down, left, right, hit,
        output frog_row, frog_col, lives, score, playing, game_over, win_pulse, die_pulse
    );
endinterface

// File: rtl/frog_mover.sv
// Frog position, lives and score keeper with the play/death/win/game-over
// sequence; consumes one-cycle move pulses and the traffic collision level.
//
// state | meaning
// PLAY  | moves and hit are processed
// DEAD  | frozen hold after a death, then respawn
// WIN   | frozen hold after a crossing, then respawn
// OVER  | no lives left; frozen until reset
module frog_mover #(
    parameter int ROWS        = 16,
    parameter int COLS        = 16,
    parameter int START_COL   = 7,
    parameter int HOLD_CYCLES = 25000000,
    parameter int LIVES       = 3,
    parameter int SCORE_W     = 4
) (
    input  logic         clk,
    input  logic         reset,
    frog_mover_if.slave  bus
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LW = $clog2(LIVES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [RW-1:0]      ROW_LAST  = RW'(ROWS - 1);
    localparam logic [CW-1:0]      COL_LAST  = CW'(COLS - 1);
    localparam logic [CW-1:0]      COL_START = CW'(START_COL);
    localparam logic [LW-1:0]      LIVES_RST = LW'(LIVES);
    localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    typedef enum logic [1:0] {PLAY, DEAD, WIN, OVER} state_t;

    state_t             state, state_nxt;
    logic [RW-1:0]      row, row_nxt;
    logic [CW-1:0]      col, col_nxt;
    logic [LW-1:0]      lives, lives_nxt;
    logic [SCORE_W-1:0] score, score_nxt;
    logic [HW-1:0]      hold_cnt, hold_cnt_nxt;
    logic               win_pulse, win_pulse_nxt;
    logic               die_pulse, die_pulse_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLAY;
            row       <= ROW_LAST;
            col       <= COL_START;
            lives     <= LIVES_RST;
            score     <= '0;
            hold_cnt  <= '0;
            win_pulse <= 1'b0;
            die_pulse <= 1'b0;
        end else begin
            state     <= state_nxt;
            row       <= row_nxt;
            col       <= col_nxt;
            lives     <= lives_nxt;
            score     <= score_nxt;
            hold_cnt  <= hold_cnt_nxt;
            win_pulse <= win_pulse_nxt;
            die_pulse <= die_pulse_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        row_nxt       = row;
        col_nxt       = col;
        lives_nxt     = lives;
        score_nxt     = score;
        hold_cnt_nxt  = hold_cnt;
        win_pulse_nxt = 1'b0;
        die_pulse_nxt = 1'b0;
        case (state)
            PLAY: begin
                // A collision wins over any move in the same cycle; the frog stays on the hit cell.
                if (bus.hit) begin
                    die_pulse_nxt = 1'b1;
                    if (lives > LW'(1)) begin
                        lives_nxt = lives - LW'(1);
                        state_nxt = DEAD;
                    end else begin
                        lives_nxt = '0;
                        state_nxt = OVER;
                    end
                end else if (bus.up) begin
                    if (row == RW'(1)) begin
                        row_nxt       = '0;
                        state_nxt     = WIN;
                        win_pulse_nxt = 1'b1;
                        if (score != SCORE_MAX) score_nxt = score + SCORE_W'(1);
                    end else if (row != '0) begin
                        row_nxt = row - RW'(1);
                    end
                end else if (bus.down) begin
                    if (row != ROW_LAST) row_nxt = row + RW'(1);
                end else if (bus.left) begin
                    if (col != '0) col_nxt = col - CW'(1);
                end else if (bus.right) begin
                    if (col != COL_LAST) col_nxt = col + CW'(1);
                end
            end
            DEAD, WIN: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = PLAY;
                    row_nxt      = ROW_LAST;
                    col_nxt      = COL_START;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + HW'(1);
                end
            end
            OVER: ;
            default: state_nxt = PLAY;
        endcase
    end

    assign bus.frog_row  = row;
    assign bus.frog_col  = col;
    assign bus.lives     = lives;
    assign bus.score     = score;
    assign bus.playing   = (state == PLAY);
    assign bus.game_over = (state == OVER);
    assign bus.win_pulse = win_pulse;
    assign bus.die_pulse = die_pulse;
endmodule
